sram_controller: RTL and testbench
==================================

# sram_controller

Sequences the memory stage's 32-bit data-memory accesses onto the board's 16-bit asynchronous SRAM. Each word access is two half-word accesses with a fixed number of wait cycles each. `ready` drives the pipeline freeze: the core stalls every stage while `ready` is low and holds its request stable until `ready` rises. The block sits between the MEM stage and the SRAM pins.

## Interface
- `WAIT_CYCLES`, default 2: cycles each half-word access is held on the pins; legal range 1..15.
- `SRAM_ADDR_W`, default 18: SRAM half-word address width.
- `DATA_BASE`, default 1024: CPU byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdEn`  in  1  read request from MEM stage.
- `wrEn`  in  1  write request from MEM stage.
- `address`  in  32  CPU byte address, word aligned.
- `writeData`  in  32  store data.
- `readData`  out  32  load data, registered.
- `ready`  out  1  access complete / no access pending; pipeline freeze = `~ready`.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  SRAM_ADDR_W  half-word address.
- `SRAM_WE_N`  out  1  write enable, active low.
- `SRAM_OE_N`  out  1  output enable, active low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  tied to 0.

## Operation
- Word address is `(address - DATA_BASE) >> 2`, truncated to SRAM_ADDR_W-1 bits.
  - Low half-word is at `{word, 1'b0}`, holding bits [15:0].
  - High half-word is at `{word, 1'b1}`, holding bits [31:16].
- FSM states are IDLE, LOW, HIGH and DONE.
  - IDLE: on `rdEn | wrEn`, latch the request kind (read wins if both are set), address and writeData, then go to LOW.
  - LOW: hold for WAIT_CYCLES cycles, then go to HIGH. For a read, capture `SRAM_DQ` into `readData[15:0]` on the last LOW cycle.
  - HIGH: hold for WAIT_CYCLES cycles, then go to DONE. For a read, capture into `readData[31:16]` on the last HIGH cycle.
  - DONE: lasts one cycle, then returns unconditionally to IDLE. The still-asserted request is not re-accepted in DONE.
- `ready` is combinational:
  - 1 in IDLE with no request, and 1 in DONE.
  - 0 otherwise.
- Pins:
  - `SRAM_WE_N` is 0 in LOW/HIGH during a write, else 1.
  - `SRAM_OE_N` is 0 in LOW/HIGH during a read, else 1.
  - `SRAM_DQ` is driven with the selected half of the latched writeData only in LOW/HIGH during a write. Otherwise it is high-Z.
  - `SRAM_ADDR` shows the current half-word address in LOW/HIGH, and 0 otherwise.
- `readData` holds its value until the next read captures. Writes do not disturb it.

## Timing
- Reset values:
  - state = IDLE, wait counter = 0, `readData` = 0, latched request cleared.
  - Outputs: `ready` = 1 (no request), `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, `SRAM_ADDR` = 0, DQ high-Z.
- Request seen in cycle 0: LOW occupies cycles 1..W, HIGH occupies W+1..2W, DONE is cycle 2W+1.
  - `ready` is 0 in cycles 0..2W and 1 in cycle 2W+1.
  - Default W=2 gives `ready` high in cycle 5, i.e. 6 cycles per access.
- Back-to-back requests: a new request is accepted on the first IDLE cycle after DONE. The minimum spacing is 2W+2 cycles.
- Reset asserted mid-access: the FSM returns to IDLE at that edge and the SRAM pins go inactive. A half-completed write may leave only the low half-word written; this is allowed.
- `rdEn`/`wrEn` changing while not in IDLE is ignored, because the latched copy is used.

## Configuration
- `SRAM_POSTED_WRITE_EN` defined:
  - A write accepted in IDLE asserts `ready` in the same cycle, so the pipeline does not stall. The FSM performs the write in the background from the latched data.
  - Any request arriving while the FSM is not IDLE sees `ready` = 0 and waits for the next IDLE.
  - Reads are unchanged.
- `SRAM_POSTED_WRITE_EN` undefined: writes stall exactly like reads, as described above.

## Structure
- Shared package holds:
  - the state typedef (IDLE, LOW, HIGH, DONE);
  - the `DATA_BASE` default;
  - the SRAM half-word width constant, 16.
- No sub-module. The wait counter, FSM, address map and tri-state driver are one flat module; the SRAM model belongs to the bench.

## Test plan
- Reset, then idle: `ready` = 1, `SRAM_WE_N`/`SRAM_OE_N` = 1, `readData` = 0, DQ high-Z.
- Write 0xDEADBEEF to address 1028 (W=2):
  - SRAM half-word 2 = 0xBEEF and half-word 3 = 0xDEAD.
  - `ready` is low for 5 cycles and high in cycle 5.
- Read address 1028 after that write: `readData` = 0xDEADBEEF in DONE, held after the request drops.
- `rdEn` and `wrEn` both set at 1032: only a read occurs and `SRAM_WE_N` never goes low.
- Reset asserted in the HIGH state of a read: next cycle state = IDLE, `ready` = 1, `readData` = 0.
- With `SRAM_POSTED_WRITE_EN`, a write followed by a read on the next cycle:
  - The write's `ready` = 1 in cycle 0.
  - The read's `ready` stays 0 until the write finishes, then the read completes 6 cycles after acceptance.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit to 16-bit asynchronous SRAM sequencer.
package sram_controller_pkg;

    // Access sequencer states: one word access = LOW half, then HIGH half.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    // CPU byte address that maps onto SRAM word 0.
    localparam int unsigned DATA_BASE_DEFAULT = 1024;

    // Width of one SRAM half-word transfer.
    localparam int unsigned SRAM_HALF_W = 16;

    // Wait counter width; covers WAIT_CYCLES up to 15.
    localparam int unsigned WAIT_CNT_W = 4;

endpackage : sram_controller_pkg

// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit MEM-stage access into two 16-bit
// asynchronous SRAM accesses (low half first), each held WAIT_CYCLES cycles.
// `ready` is the pipeline freeze control (freeze = ~ready).
// Optional feature macro: SRAM_POSTED_WRITE_EN -- writes are acknowledged in
// the accepting cycle and finish in the background.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned DATA_BASE   = DATA_BASE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdEn,
    input  logic                   wrEn,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int unsigned WORD_W = SRAM_ADDR_W - 1;
    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES - 1);

    sram_state_e                 state_q;
    logic [WAIT_CNT_W-1:0]       wait_cnt_q;
    logic                        op_read_q;
    logic [WORD_W-1:0]           word_q;
    logic [WORD_W-1:0]           word_d;
    logic [31:0]                 wdata_q;
    logic [31:0]                 read_data_q;

    logic                        we_n_q;
    logic                        oe_n_q;
    logic [SRAM_ADDR_W-1:0]      addr_q;
    logic                        dq_oe_q;
    logic [SRAM_HALF_W-1:0]      dq_out_q;

    logic                        req;
    logic                        last_wait;

    assign req       = rdEn | wrEn;
    assign last_wait = (wait_cnt_q == LAST_CNT);

    // CPU byte address to SRAM word index, truncated to the SRAM word space.
    assign word_d = WORD_W'((address - DATA_BASE) >> 2);

    // Access sequencer: latches the request, walks LOW/HIGH with the wait
    // counter, captures read halves and registers every SRAM pin.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            op_read_q   <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            addr_q      <= '0;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        // Read wins when both requests are raised together.
                        op_read_q  <= rdEn;
                        word_q     <= word_d;
                        wdata_q    <= writeData;
                        wait_cnt_q <= '0;
                        state_q    <= ST_LOW;
                        addr_q     <= {word_d, 1'b0};
                        we_n_q     <= rdEn;
                        oe_n_q     <= ~rdEn;
                        dq_oe_q    <= ~rdEn;
                        dq_out_q   <= writeData[15:0];
                    end
                end
                ST_LOW: begin
                    if (last_wait) begin
                        if (op_read_q) begin
                            read_data_q[15:0] <= SRAM_DQ;
                        end
                        wait_cnt_q <= '0;
                        state_q    <= ST_HIGH;
                        addr_q     <= {word_q, 1'b1};
                        dq_out_q   <= wdata_q[31:16];
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (last_wait) begin
                        if (op_read_q) begin
                            read_data_q[31:16] <= SRAM_DQ;
                        end
                        wait_cnt_q <= '0;
                        state_q    <= ST_DONE;
                        addr_q     <= '0;
                        we_n_q     <= 1'b1;
                        oe_n_q     <= 1'b1;
                        dq_oe_q    <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // The still-held request is not re-accepted here.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline handshake: high when nothing is pending or the access is done.
    // NOTE: ready gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            ST_IDLE: ready = ~req;
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
`ifdef SRAM_POSTED_WRITE_EN
        // A lone write is acknowledged on acceptance.
        if (state_q == ST_IDLE && wrEn && !rdEn) begin
            ready = 1'b1;
        end
        // A background write only stalls a core that presents a new request.
        if (state_q != ST_IDLE && !op_read_q) begin
            ready = ~req;
        end
`endif
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign readData  = read_data_q;

endmodule : sram_controller

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM plus a word-level
// reference model. Honours SRAM_POSTED_WRITE_EN when defined.
module tb_sram_controller;

    localparam int unsigned W         = 2;
    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned DATA_BASE = 1024;
    localparam int          ACC_CYC   = 2 * W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdEn;
    logic              wrEn;
    logic [31:0]       address;
    logic [31:0]       writeData;
    logic [31:0]       readData;
    logic              ready;
    wire  [15:0]       sram_dq;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic              sram_ce_n;
    logic              sram_ub_n;
    logic              sram_lb_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sram_controller #(
        .WAIT_CYCLES(W),
        .SRAM_ADDR_W(ADDR_W),
        .DATA_BASE  (DATA_BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdEn     (rdEn),
        .wrEn     (wrEn),
        .address  (address),
        .writeData(writeData),
        .readData (readData),
        .ready    (ready),
        .SRAM_DQ  (sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(sram_we_n),
        .SRAM_OE_N(sram_oe_n),
        .SRAM_CE_N(sram_ce_n),
        .SRAM_UB_N(sram_ub_n),
        .SRAM_LB_N(sram_lb_n)
    );

    // Behavioural asynchronous SRAM (16-bit half-words).
    logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
    logic [15:0] sram_rd;
    assign sram_rd = sram_mem[sram_addr];
    assign sram_dq = (!sram_oe_n) ? sram_rd : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
    end

    // Pin activity monitor, sampled mid-cycle.
    int we_cnt = 0;
    int oe_cnt = 0;
    int clash_cnt = 0;
    always @(negedge clk) begin
        if (!sram_we_n) we_cnt++;
        if (!sram_oe_n) oe_cnt++;
        if (!sram_we_n && !sram_oe_n) clash_cnt++;
    end

    // Reference model: 32-bit words indexed by CPU word offset.
    logic [31:0] exp_mem [int];
    logic [31:0] exp_rdata;

    function automatic logic [31:0] model_read(input int word);
        return exp_mem.exists(word) ? exp_mem[word] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic drop_req();
        rdEn = 1'b0;
        wrEn = 1'b0;
    endtask

    // One complete MEM-stage access, checked against the model.
    task automatic access(input logic rd, input logic wr, input int word, input logic [31:0] data);
        int lat;
        int we0;
        int oe0;
        @(negedge clk);
        rdEn      = rd;
        wrEn      = wr;
        address   = DATA_BASE + 32'(word) * 4;
        writeData = data;
        we0 = we_cnt;
        oe0 = oe_cnt;
        #1;
`ifdef SRAM_POSTED_WRITE_EN
        if (!rd) begin
            check("posted_ready_c0", {31'b0, ready}, 32'h1);
            @(negedge clk);
            drop_req();
            repeat (ACC_CYC) @(negedge clk);
            check("posted_idle_ready", {31'b0, ready}, 32'h1);
        end else
`endif
        begin
            lat = 0;
            while (ready !== 1'b1 && lat < 50) begin
                lat++;
                @(negedge clk);
            end
            check("ready_latency", lat, ACC_CYC);
            if (rd) check("rdata_done", readData, model_read(word));
            drop_req();
            @(negedge clk);
        end
        if (rd) begin
            exp_rdata = model_read(word);
            check("rdata_held", readData, exp_rdata);
            check("we_during_read", we_cnt - we0, 0);
            check("oe_during_read", oe_cnt - oe0, 2 * W);
        end else begin
            exp_mem[word] = data;
            check("rdata_kept", readData, exp_rdata);
            check("mem_lo", {16'h0, sram_mem[2 * word]},     {16'h0, data[15:0]});
            check("mem_hi", {16'h0, sram_mem[2 * word + 1]}, {16'h0, data[31:16]});
            check("we_during_write", we_cnt - we0, 2 * W);
            check("oe_during_write", oe_cnt - oe0, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = 16'h0;
        exp_rdata = 32'h0;
        rst = 1'b1;
        drop_req();
        address   = 32'h0;
        writeData = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Reset / idle state.
        check("rst_ready",  {31'b0, ready},     32'h1);
        check("rst_we_n",   {31'b0, sram_we_n}, 32'h1);
        check("rst_oe_n",   {31'b0, sram_oe_n}, 32'h1);
        check("rst_rdata",  readData,           32'h0);
        check("rst_addr",   32'(sram_addr),     32'h0);
        check("rst_dq_z",   {31'b0, sram_dq === 16'hzzzz}, 32'h1);
        check("tied_pins",  {29'b0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h0);

        // Directed: write 1028, read back, read-wins at 1032.
        access(1'b0, 1'b1, 1, 32'hDEADBEEF);
        check("mem_hw2", {16'h0, sram_mem[2]}, 32'h0000BEEF);
        check("mem_hw3", {16'h0, sram_mem[3]}, 32'h0000DEAD);
        access(1'b1, 1'b0, 1, 32'h0);
        check("read_1028", readData, 32'hDEADBEEF);
        access(1'b1, 1'b1, 2, 32'h12345678);

        // Randomized traffic over a small word window.
        for (int n = 0; n < 30; n++) begin
            int          word;
            int          kind;
            logic [31:0] d;
            word = int'($urandom_range(0, 15));
            kind = int'($urandom_range(0, 2));
            d    = $urandom;
            access(kind != 1, kind != 0, word, d);
        end

        // Reset in the HIGH state of a read.
        access(1'b0, 1'b1, 3, 32'hA5A55A5A);
        access(1'b1, 1'b0, 3, 32'h0);
        @(negedge clk);
        rdEn    = 1'b1;
        address = DATA_BASE + 32'd12;
        repeat (W + 1) @(negedge clk);
        check("high_addr", 32'(sram_addr), 32'd7);
        check("high_oe_n", {31'b0, sram_oe_n}, 32'h0);
        rst = 1'b1;
        drop_req();
        @(negedge clk);
        check("mid_rst_ready", {31'b0, ready},     32'h1);
        check("mid_rst_rdata", readData,           32'h0);
        check("mid_rst_oe_n",  {31'b0, sram_oe_n}, 32'h1);
        check("mid_rst_addr",  32'(sram_addr),     32'h0);
        rst = 1'b0;
        exp_rdata = 32'h0;
        access(1'b1, 1'b0, 3, 32'h0);

`ifdef SRAM_POSTED_WRITE_EN
        // Posted write followed immediately by a read of the same word.
        begin
            int cyc;
            @(negedge clk);
            wrEn      = 1'b1;
            address   = DATA_BASE + 32'd20;
            writeData = 32'hCAFEF00D;
            #1;
            check("posted_wr_c0", {31'b0, ready}, 32'h1);
            @(negedge clk);
            wrEn = 1'b0;
            rdEn = 1'b1;
            cyc  = 1;
            #1;
            while (ready !== 1'b1 && cyc < 60) begin
                @(negedge clk);
                cyc++;
            end
            check("posted_rd_cycle", cyc, 2 * ACC_CYC + 1);
            check("posted_rd_data", readData, 32'hCAFEF00D);
            drop_req();
            exp_mem[5] = 32'hCAFEF00D;
            exp_rdata  = 32'hCAFEF00D;
            @(negedge clk);
        end
`endif

        check("bus_clash", clash_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sram_controller
